io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the single memory-mapped IO bus (address decoder -> LED/DIP/7-seg
//  drivers) between two masters: M0 = processor core IO port, M1 = secondary
//  master (debug loader / DMA). Registered request/grant, round-robin on
//  contention, bounded burst tenure. Sits between the masters and the
//  peripheral address decoder.
// PARAMETERS
//  MAX_BURST   4   transfers a master may issue per tenure while the other waits (>=1)
//  CNT_W       3   width of tenure counter; must hold MAX_BURST
// PORTS
//  CLK         in   1   system clock, all state on rising edge
//  Reset       in   1   asynchronous, active-high reset
//  M0_REQ      in   1   M0 requests bus / transfer valid this cycle
//  M0_ADDR     in   32  M0 address
//  M0_WD       in   32  M0 write data
//  M0_WE       in   1   M0 write enable (0 = read)
//  M0_GNT      out  1   M0 owns bus; transfer occurs on cycles with M0_REQ&M0_GNT
//  M0_RDATA    out  32  read data for M0's last read
//  M0_RVALID   out  1   one-cycle pulse: M0_RDATA valid
//  M1_*        --   --  identical set for M1 (REQ, ADDR, WD, WE, GNT, RDATA, RVALID)
//  BUS_ADDR    out  32  to decoder: granted master's ADDR, else 0
//  BUS_WD      out  32  to decoder: granted master's WD, else 0
//  BUS_WE      out  1   to decoder: granted master's WE & REQ, else 0
//  BUS_RD      in   32  combinational read data from decoder
// BEHAVIOUR
//  - States: IDLE, OWN0, OWN1 (2-bit reg). GNTx = (state==OWNx), registered.
//  - Reset (async): state=IDLE, LAST=1 (so M0 wins first tie), cnt=0,
//    GNTs=0, RVALIDs=0, RDATAs=0; BUS_* = 0 while IDLE.
//  - IDLE: only M0_REQ -> OWN0; only M1_REQ -> OWN1; both -> OWN(!LAST).
//    Grant latency: GNT high the cycle after REQ first seen (1 cycle).
//  - Transfer = cycle with REQx & GNTx. BUS_* muxed combinationally from owner;
//    BUS_WE = WEx & REQx (never high without grant).
//  - Read: on a transfer with WEx=0, RDATAx <= BUS_RD, RVALIDx=1 next cycle;
//    RVALID is a 1-cycle pulse; RDATA holds until next read.
//  - cnt increments on each transfer in OWNx, cleared on every state change.
//  - OWNx exit (evaluated each edge, priority order):
//    1) REQx=0: other REQ -> OWN(other), else -> IDLE; transfer not counted.
//    2) transfer makes cnt reach MAX_BURST and other REQ=1 -> OWN(other)
//       (the MAX_BURST-th transfer completes; GNTx drops next cycle).
//    3) cnt reaches MAX_BURST, other idle -> stay OWNx, cnt <= 0.
//  - LAST <= x whenever leaving OWNx. Direct OWN0<->OWN1 handover has no
//    idle cycle; the two GNTs are never high together.
//  - Master must hold ADDR/WD/WE stable while REQ=1 and GNT=0.
//  - Reset mid-tenure: GNT drops immediately, pending RVALID suppressed.
//  - MAX_BURST=1: strict alternation under continuous contention.
// TESTING
//  1 Reset, M0_REQ=1 read 0x...F0 -> M0_GNT cycle 1; BUS_ADDR=0x...F0, BUS_WE=0;
//    RVALID pulse cycle 2 with RDATA=BUS_RD; M1_GNT stays 0.
//  2 M0,M1 both REQ from reset, MAX_BURST=4 -> M0 gets 4 transfers, then
//    M1 4, then M0 ...; GNTs never overlap; no idle cycle at handover.
//  3 M1 owns, drops REQ after 2 transfers while M0_REQ=1 -> M0_GNT next
//    cycle; then both idle -> IDLE, BUS_WE=0, BUS_ADDR=0.
//  4 M0 alone writes 10 times 0x...10/0x1234 -> BUS_WE high 10 cycles, cnt
//    wraps at 4 without GNT loss; LED reg updates per write.
//  5 Assert Reset in OWN1 with a read in flight -> GNT, RVALID, BUS_WE low
//    same cycle; after release M0 wins first tie (LAST=1).
//  6 Ungranted master asserts WE=1 -> BUS_WE never reflects it (assertion).

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the IO bus; grant registered (1 cycle after REQ), reads return 1 cycle after transfer.
// Masters stall on GNT=0; a tenure is capped at MAX_BURST transfers when the other master is waiting.
module io_bus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        M0_REQ,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WD,
  input  logic        M0_WE,
  output logic        M0_GNT,
  output logic [31:0] M0_RDATA,
  output logic        M0_RVALID,
  input  logic        M1_REQ,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WD,
  input  logic        M1_WE,
  output logic        M1_GNT,
  output logic [31:0] M1_RDATA,
  output logic        M1_RVALID,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WD,
  output logic        BUS_WE,
  input  logic [31:0] BUS_RD
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid0_q, rvalid1_q;
  logic [31:0]      rdata0_q, rdata1_q;

  logic             own0, own1, xfer0, xfer1, burst_done;
  logic [CNT_W-1:0] cnt_inc;

  assign own0       = (state_q == S_OWN0);
  assign own1       = (state_q == S_OWN1);
  assign xfer0      = own0 & M0_REQ;
  assign xfer1      = own1 & M1_REQ;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign burst_done = (cnt_inc == BURST_MAX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // last_q=1 means M1 owned last, so M0 wins a tie
        if (M0_REQ && (!M1_REQ || last_q)) state_d = S_OWN0;
        else if (M1_REQ)                   state_d = S_OWN1;
      end
      S_OWN0: begin
        if (!M0_REQ) begin
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = M1_REQ ? S_OWN1 : S_IDLE;
        end else if (burst_done) begin
          cnt_d = '0;
          if (M1_REQ) begin
            state_d = S_OWN1;
            last_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_OWN1: begin
        if (!M1_REQ) begin
          cnt_d   = '0;
          last_d  = 1'b1;
          state_d = M0_REQ ? S_OWN0 : S_IDLE;
        end else if (burst_done) begin
          cnt_d = '0;
          if (M0_REQ) begin
            state_d = S_OWN0;
            last_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    BUS_ADDR = '0;
    BUS_WD   = '0;
    BUS_WE   = 1'b0;
    if (own0) begin
      BUS_ADDR = M0_ADDR;
      BUS_WD   = M0_WD;
      BUS_WE   = M0_WE & M0_REQ;
    end else if (own1) begin
      BUS_ADDR = M1_ADDR;
      BUS_WD   = M1_WD;
      BUS_WE   = M1_WE & M1_REQ;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= xfer0 & ~M0_WE;
      rvalid1_q <= xfer1 & ~M1_WE;
      if (xfer0 && !M0_WE) rdata0_q <= BUS_RD;
      if (xfer1 && !M1_WE) rdata1_q <= BUS_RD;
    end
  end

  assign M0_GNT    = own0;
  assign M1_GNT    = own1;
  assign M0_RVALID = rvalid0_q;
  assign M1_RVALID = rvalid1_q;
  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: stimulus queues cycle-stamped expected
// transfers/read returns, a negedge monitor pops and compares them.
module tb_io_bus_arbiter;

  typedef struct {
    int          cyc;
    logic        m;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } xfer_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;

  logic        CLK, Reset;
  logic        M0_REQ, M0_WE, M0_GNT, M0_RVALID;
  logic [31:0] M0_ADDR, M0_WD, M0_RDATA;
  logic        M1_REQ, M1_WE, M1_GNT, M1_RVALID;
  logic [31:0] M1_ADDR, M1_WD, M1_RDATA;
  logic [31:0] BUS_ADDR, BUS_WD, BUS_RD;
  logic        BUS_WE;
  logic [31:0] led_q;

  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  xfer_t xq[$];
  rd_t   rq0[$];
  rd_t   rq1[$];

  io_bus_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .CLK(CLK), .Reset(Reset),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WD(M0_WD), .M0_WE(M0_WE),
    .M0_GNT(M0_GNT), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WD(M1_WD), .M1_WE(M1_WE),
    .M1_GNT(M1_GNT), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
    .BUS_ADDR(BUS_ADDR), .BUS_WD(BUS_WD), .BUS_WE(BUS_WE), .BUS_RD(BUS_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  // Peripheral model: LED register at 0x10, every other address reads back ~addr
  initial led_q = 32'h0;
  always @(posedge CLK) if (BUS_WE && BUS_ADDR == 32'h10) led_q <= BUS_WD;
  assign BUS_RD = (BUS_ADDR == 32'h10) ? led_q : ~BUS_ADDR;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_x(input int c, input logic m, input logic [31:0] a, input logic we, input logic [31:0] wd);
    xfer_t e;
    e.cyc = c; e.m = m; e.addr = a; e.we = we; e.wd = wd;
    xq.push_back(e);
  endtask

  task automatic push_r(input logic m, input int c, input logic [31:0] d);
    rd_t r;
    r.cyc = c; r.data = d;
    if (m) rq1.push_back(r);
    else   rq0.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    M0_REQ = 1'b0; M0_WE = 1'b0; M0_ADDR = '0; M0_WD = '0;
    M1_REQ = 1'b0; M1_WE = 1'b0; M1_ADDR = '0; M1_WD = '0;
    tick(2);
    chk("rst_m0_gnt", 32'(M0_GNT), 32'h0);
    chk("rst_m1_gnt", 32'(M1_GNT), 32'h0);
    chk("rst_m0_rvalid", 32'(M0_RVALID), 32'h0);
    chk("rst_m1_rvalid", 32'(M1_RVALID), 32'h0);
    chk("rst_m0_rdata", M0_RDATA, 32'h0);
    chk("rst_m1_rdata", M1_RDATA, 32'h0);
    chk("rst_bus_addr", BUS_ADDR, 32'h0);
    chk("rst_bus_wd", BUS_WD, 32'h0);
    chk("rst_bus_we", 32'(BUS_WE), 32'h0);
    Reset = 1'b0;
    tick(1);
  endtask

  // Monitor: bus invariants every cycle, transfers and read returns against the queues
  always @(negedge CLK) begin
    xfer_t e;
    rd_t   r;
    logic  exp_we;
    if (!Reset) begin
      chk("gnt_overlap", 32'(M0_GNT & M1_GNT), 32'h0);
      exp_we = M0_GNT ? (M0_WE & M0_REQ) : (M1_GNT ? (M1_WE & M1_REQ) : 1'b0);
      chk("bus_we_owner", 32'(BUS_WE), 32'(exp_we));
      if ((M0_GNT && M0_REQ) || (M1_GNT && M1_REQ)) begin
        if (xq.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer_unexpected actual=M%0d addr=%h required=none (cycle %0d)", M1_GNT, BUS_ADDR, cyc);
        end else begin
          e = xq.pop_front();
          chk("xfer_cycle", cyc, e.cyc);
          chk("xfer_master", 32'(M1_GNT), 32'(e.m));
          chk("xfer_addr", BUS_ADDR, e.addr);
          chk("xfer_we", 32'(BUS_WE), 32'(e.we));
          chk("xfer_wd", BUS_WD, e.wd);
        end
      end
      if (M0_RVALID) begin
        if (rq0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_rvalid_unexpected actual=%h required=none (cycle %0d)", M0_RDATA, cyc);
        end else begin
          r = rq0.pop_front();
          chk("m0_rvalid_cycle", cyc, r.cyc);
          chk("m0_rdata", M0_RDATA, r.data);
        end
      end
      if (M1_RVALID) begin
        if (rq1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_rvalid_unexpected actual=%h required=none (cycle %0d)", M1_RDATA, cyc);
        end else begin
          r = rq1.pop_front();
          chk("m1_rvalid_cycle", cyc, r.cyc);
          chk("m1_rdata", M1_RDATA, r.data);
        end
      end
    end
  end

  initial begin
    int b;
    do_reset();

    // Single M0 read from reset
    b = cyc;
    M0_REQ = 1'b1; M0_ADDR = 32'hFFFF_FFF0; M0_WE = 1'b0; M0_WD = 32'h0;
    push_x(b + 1, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h0);
    push_r(1'b0, b + 2, 32'h0000_000F);
    tick(1);
    chk("t1_m0_gnt", 32'(M0_GNT), 32'h1);
    chk("t1_m1_gnt", 32'(M1_GNT), 32'h0);
    tick(1);
    M0_REQ = 1'b0;
    tick(3);

    // Continuous contention from reset: 4/4/4 alternation with no gap
    do_reset();
    b = cyc;
    M0_REQ = 1'b1; M0_ADDR = 32'h100; M0_WE = 1'b1; M0_WD = 32'hAAAA_0000;
    M1_REQ = 1'b1; M1_ADDR = 32'h200; M1_WE = 1'b0; M1_WD = 32'h0;
    for (int i = 0; i < 4; i++) push_x(b + 1 + i, 1'b0, 32'h100, 1'b1, 32'hAAAA_0000);
    for (int i = 0; i < 4; i++) begin
      push_x(b + 5 + i, 1'b1, 32'h200, 1'b0, 32'h0);
      push_r(1'b1, b + 6 + i, ~32'h200);
    end
    for (int i = 0; i < 4; i++) push_x(b + 9 + i, 1'b0, 32'h100, 1'b1, 32'hAAAA_0000);
    tick(13);
    M0_REQ = 1'b0; M1_REQ = 1'b0; M0_WE = 1'b0;
    tick(3);

    // M1 drops after two writes while M0 waits; ungranted M0 keeps nothing on the bus
    b = cyc;
    M1_REQ = 1'b1; M1_ADDR = 32'h300; M1_WE = 1'b1; M1_WD = 32'h5;
    M0_ADDR = 32'h400; M0_WE = 1'b0; M0_WD = 32'h0;
    push_x(b + 1, 1'b1, 32'h300, 1'b1, 32'h5);
    push_x(b + 2, 1'b1, 32'h300, 1'b1, 32'h5);
    push_x(b + 4, 1'b0, 32'h400, 1'b0, 32'h0);
    push_r(1'b0, b + 5, ~32'h400);
    tick(1);
    M0_REQ = 1'b1;
    tick(2);
    M1_REQ = 1'b0;
    tick(2);
    M0_REQ = 1'b0;
    tick(1);
    chk("t3_idle_bus_we", 32'(BUS_WE), 32'h0);
    chk("t3_idle_bus_addr", BUS_ADDR, 32'h0);
    chk("t3_idle_m0_gnt", 32'(M0_GNT), 32'h0);
    chk("t3_idle_m1_gnt", 32'(M1_GNT), 32'h0);
    M1_WE = 1'b0;
    tick(2);

    // M0 alone: ten LED writes straight through the counter wrap, then read back
    b = cyc;
    M0_REQ = 1'b1; M0_ADDR = 32'h10; M0_WE = 1'b1; M0_WD = 32'h1230;
    for (int i = 0; i < 10; i++) push_x(b + 1 + i, 1'b0, 32'h10, 1'b1, 32'h1230 + 32'(i));
    push_x(b + 11, 1'b0, 32'h10, 1'b0, 32'h1239);
    push_r(1'b0, b + 12, 32'h1239);
    tick(1);
    for (int i = 1; i < 10; i++) begin
      tick(1);
      M0_WD = 32'h1230 + 32'(i);
    end
    tick(1);
    M0_WE = 1'b0;
    tick(1);
    M0_REQ = 1'b0;
    tick(3);
    chk("t4_led", led_q, 32'h1239);

    // Reset during an M1 read, then M0 must win the first tie
    b = cyc;
    M1_REQ = 1'b1; M1_ADDR = 32'h500; M1_WE = 1'b0; M1_WD = 32'h0;
    push_x(b + 1, 1'b1, 32'h500, 1'b0, 32'h0);
    tick(1);
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    chk("t5_rst_m1_gnt", 32'(M1_GNT), 32'h0);
    chk("t5_rst_bus_we", 32'(BUS_WE), 32'h0);
    chk("t5_rst_m1_rvalid", 32'(M1_RVALID), 32'h0);
    tick(1);
    chk("t5_rst_m1_rvalid_hold", 32'(M1_RVALID), 32'h0);
    Reset = 1'b0;
    M0_REQ = 1'b1; M0_ADDR = 32'h600; M0_WE = 1'b0; M0_WD = 32'h0;
    b = cyc;
    push_x(b + 1, 1'b0, 32'h600, 1'b0, 32'h0);
    push_r(1'b0, b + 2, ~32'h600);
    push_x(b + 3, 1'b1, 32'h500, 1'b0, 32'h0);
    push_r(1'b1, b + 4, ~32'h500);
    tick(2);
    M0_REQ = 1'b0;
    tick(2);
    M1_REQ = 1'b0;
    tick(4);

    chk("xq_drained", 32'(xq.size()), 32'h0);
    chk("rq0_drained", 32'(rq0.size()), 32'h0);
    chk("rq1_drained", 32'(rq1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
